// File: rtl/vga_pattern_sequencer_if.sv
// rtl/vga_pattern_sequencer_if.sv - pixel position, pattern bank and RGB bus between generators, sequencer and VGA controller
interface vga_pattern_sequencer_if #(
    parameter int NUM_PAT = 5
);
    logic [9:0]           iVGA_X;
    logic [9:0]           iVGA_Y;
    logic [NUM_PAT*10-1:0] iPAT_R;
    logic [NUM_PAT*10-1:0] iPAT_G;
    logic [NUM_PAT*10-1:0] iPAT_B;
    logic [9:0]           oRed;
    logic [9:0]           oGreen;
    logic [9:0]           oBlue;

    modport slave (
        input  iVGA_X, iVGA_Y, iPAT_R, iPAT_G, iPAT_B,
        output oRed, oGreen, oBlue
    );

    modport master (
        output iVGA_X, iVGA_Y, iPAT_R, iPAT_G, iPAT_B,
        input  oRed, oGreen, oBlue
    );
endinterface

// File: rtl/vga_pattern_sequencer.sv
// rtl/vga_pattern_sequencer.sv - frame-aligned pattern scheduler with black-frame insertion
// Optional top-left index bar when VGA_PAT_SEQ_OSD_EN is defined.
module vga_pattern_sequencer #(
    parameter int NUM_PAT      = 5,
    parameter int DWELL_FRAMES = 120,
    parameter int BLANK_FRAMES = 2
) (
    input  logic                          iVGA_CLK,
    input  logic                          iRST_N,
    vga_pattern_sequencer_if.slave        vga,
    input  logic                          iNEXT,
    input  logic                          iAUTO,
    output logic [2:0]                    oPAT_SEL,
    output logic                          oFRAME_START,
    output logic                          oBLANKING
);
    typedef enum logic [1:0] {
        ST_SHOW  = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam logic [2:0] LAST_SEL   = 3'(NUM_PAT - 1);
    localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);
    localparam logic [7:0] BLANK_INIT = 8'(BLANK_FRAMES);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] blank_q, blank_d;
    logic       prev_origin_q;
    logic       fs_q;
    logic       blanking_q;
    logic [9:0] red_q, red_d;
    logic [9:0] green_q, green_d;
    logic [9:0] blue_q, blue_d;

    logic       origin;
    logic       fs;
    logic       do_switch;
    logic [9:0] pat_r, pat_g, pat_b;

    assign origin = (vga.iVGA_X == 10'd0) && (vga.iVGA_Y == 10'd0);
    assign fs     = origin && !prev_origin_q;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dwell_d   = dwell_q;
        blank_d   = blank_q;
        do_switch = 1'b0;

        case (state_q)
            ST_SHOW: begin
                if (fs) begin
                    if (iNEXT) begin
                        do_switch = 1'b1;
                    end else if (iAUTO) begin
                        if (dwell_q == DWELL_LAST) begin
                            do_switch = 1'b1;
                        end else begin
                            dwell_d = dwell_q + 8'd1;
                        end
                    end
                end else if (iNEXT) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // Extra iNEXT pulses fall through here: only one switch is ever pending.
                if (fs) begin
                    do_switch = 1'b1;
                end
            end
            ST_BLANK: begin
                dwell_d = 8'd0;
                if (fs) begin
                    blank_d = blank_q - 8'd1;
                    if (blank_q == 8'd1) begin
                        state_d = ST_SHOW;
                    end
                end
            end
            default: begin
                state_d = ST_SHOW;
            end
        endcase

        if (!iAUTO) begin
            dwell_d = 8'd0;
        end

        // A single switch point keeps coincident next/dwell/pending events to one step.
        if (do_switch) begin
            sel_d   = (sel_q == LAST_SEL) ? 3'd0 : sel_q + 3'd1;
            dwell_d = 8'd0;
            if (BLANK_FRAMES != 0) begin
                blank_d = BLANK_INIT;
                state_d = ST_BLANK;
            end else begin
                state_d = ST_SHOW;
            end
        end
    end

    always_comb begin
        pat_r = 10'd0;
        pat_g = 10'd0;
        pat_b = 10'd0;
        for (int k = 0; k < NUM_PAT; k++) begin
            if (sel_d == 3'(k)) begin
                pat_r = vga.iPAT_R[k*10 +: 10];
                pat_g = vga.iPAT_G[k*10 +: 10];
                pat_b = vga.iPAT_B[k*10 +: 10];
            end
        end
    end

`ifdef VGA_PAT_SEQ_OSD_EN
    logic [9:0] osd_xlim;
    assign osd_xlim = {4'd0, sel_d, 3'd0} + 10'd8;

    always_comb begin
        red_d   = pat_r;
        green_d = pat_g;
        blue_d  = pat_b;
        if (state_d == ST_BLANK) begin
            red_d   = 10'd0;
            green_d = 10'd0;
            blue_d  = 10'd0;
        end else if ((vga.iVGA_Y < 10'd8) && (vga.iVGA_X < osd_xlim)) begin
            red_d   = 10'd1023;
            green_d = 10'd0;
            blue_d  = 10'd0;
        end
    end
`else
    always_comb begin
        red_d   = pat_r;
        green_d = pat_g;
        blue_d  = pat_b;
        if (state_d == ST_BLANK) begin
            red_d   = 10'd0;
            green_d = 10'd0;
            blue_d  = 10'd0;
        end
    end
`endif

    // Outputs are registered from next-state so the first black pixel lands right after the switching fs.
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q       <= ST_SHOW;
            sel_q         <= 3'd0;
            dwell_q       <= 8'd0;
            blank_q       <= 8'd0;
            prev_origin_q <= 1'b1;
            fs_q          <= 1'b0;
            blanking_q    <= 1'b0;
            red_q         <= 10'd0;
            green_q       <= 10'd0;
            blue_q        <= 10'd0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            dwell_q       <= dwell_d;
            blank_q       <= blank_d;
            prev_origin_q <= origin;
            fs_q          <= fs;
            blanking_q    <= (state_d == ST_BLANK);
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign vga.oRed     = red_q;
    assign vga.oGreen   = green_q;
    assign vga.oBlue    = blue_q;
    assign oPAT_SEL     = sel_q;
    assign oFRAME_START = fs_q;
    assign oBLANKING    = blanking_q;
endmodule

// File: doc/vga_pattern_sequencer.md
Name: vga_pattern_sequencer

Overview:
Schedules a bank of VGA test-pattern generators onto the single RGB output path. Selects one generator at a time and switches only on frame boundaries, on a user "next" request or after an auto-dwell period. Inserts black frames on every switch so the monitor never sees a torn frame. Sits between the pattern generators and the VGA controller RGB inputs.

Parameters:
NUM_PAT, 5, number of pattern generators attached (legal range 2..8)
DWELL_FRAMES, 120, frames shown per pattern in auto mode (legal range 1..255)
BLANK_FRAMES, 2, full black frames inserted on each switch (0 disables blanking)

Ports:
iVGA_CLK  in  1  pixel clock
iRST_N  in  1  asynchronous, active-low reset
iVGA_X  in  10  current pixel column from the VGA controller
iVGA_Y  in  10  current pixel row from the VGA controller
iPAT_R  in  NUM_PAT*10  packed red outputs; pattern k occupies bits [10k+9:10k]
iPAT_G  in  NUM_PAT*10  packed green outputs, same packing
iPAT_B  in  NUM_PAT*10  packed blue outputs, same packing
iNEXT  in  1  single-cycle synchronous request to advance to the next pattern
iAUTO  in  1  level; 1 enables auto-advance after DWELL_FRAMES frames
oRed  out  10  selected red, registered
oGreen  out  10  selected green, registered
oBlue  out  10  selected blue, registered
oPAT_SEL  out  3  index of the active pattern
oFRAME_START  out  1  one-cycle pulse, registered copy of the frame-start strobe
oBLANKING  out  1  1 while in BLANK state

Behaviour:
- Reset is iRST_N, asynchronous, active-low. Clock is iVGA_CLK.
- Reset values: oRed/oGreen/oBlue=0, oPAT_SEL=0, oFRAME_START=0, oBLANKING=0, state=SHOW, dwell_cnt=0, blank_cnt=0. The prev_origin register resets to 1.
- Frame-start strobe fs = (iVGA_X==0 && iVGA_Y==0) && !prev_origin. prev_origin <= (iVGA_X==0 && iVGA_Y==0) every cycle. No fs is generated on the first cycle after reset.
- States:
  - SHOW: outputs pattern oPAT_SEL.
  - PEND: switch requested; still outputs pattern oPAT_SEL.
  - BLANK: outputs 0 on all channels.
- SHOW transitions:
  - iNEXT=1 with no fs in the same cycle -> PEND.
  - On fs with iAUTO=1: if dwell_cnt==DWELL_FRAMES-1, do a switch; otherwise dwell_cnt++.
  - iNEXT and fs in the same cycle -> switch immediately.
  - iAUTO=0 -> dwell_cnt held at 0.
- PEND transitions: on the next fs, do a switch. Additional iNEXT pulses are ignored (no queuing).
- Switch (always on an fs cycle):
  - oPAT_SEL <= (oPAT_SEL==NUM_PAT-1) ? 0 : oPAT_SEL+1.
  - dwell_cnt <= 0.
  - If BLANK_FRAMES>0: blank_cnt <= BLANK_FRAMES and state -> BLANK. Otherwise state -> SHOW.
- Simultaneous events advance by exactly one index. This covers PEND together with dwell expiry, and iNEXT together with dwell expiry.
- BLANK transitions:
  - On each fs, blank_cnt--. On the fs where blank_cnt==1, go to SHOW.
  - This gives exactly BLANK_FRAMES black frames.
  - iNEXT is ignored in BLANK. dwell_cnt is held at 0 in BLANK.
- Datapath latency is 1 cycle. RGB registered at cycle n reflects the iPAT_* inputs and state at cycle n-1. The first black pixel is on the cycle after the switching fs. oBLANKING, oPAT_SEL and oFRAME_START are updated on that same cycle.
- Widths: dwell_cnt and blank_cnt are 8 bits. oPAT_SEL is zero-extended to 3 bits. Pattern indices >= NUM_PAT never occur.
- Reset mid-frame or mid-BLANK returns the block to pattern 0 in SHOW on the next clock edge. RGB outputs go to 0 immediately (asynchronous).

Optional Feature:
Macro: VGA_PAT_SEQ_OSD_EN
- Defined: in SHOW and PEND, pixels with iVGA_Y<8 and iVGA_X<8*(oPAT_SEL+1) are forced to oRed=1023, oGreen=0, oBlue=0. This draws an index bar in the top-left corner. The bar uses the same 1-cycle latency as the datapath. No overlay is drawn in BLANK.
- Undefined: no overlay logic; RGB is the pure selected pattern.

Test Plan:
1. Reset release with X=Y=0 held -> no oFRAME_START, oPAT_SEL=0, RGB equals pattern 0 one cycle later.
2. iNEXT pulse mid-frame at (320,240), BLANK_FRAMES=2 -> state PEND, pattern 0 shown to end of frame. At next fs oPAT_SEL=1 and oBLANKING=1 with RGB=0 for exactly 2 frames, then pattern 1.
3. iAUTO=1, DWELL_FRAMES=3, BLANK_FRAMES=0, oPAT_SEL=4, NUM_PAT=5 -> switch after the 3rd fs, oPAT_SEL wraps to 0, no black frame.
4. iNEXT in the same cycle as the dwell-expiry fs -> oPAT_SEL advances by exactly 1. Three iNEXT pulses in one frame -> advance by 1.
5. iRST_N asserted during BLANK with blank_cnt=1 -> RGB=0 immediately. After release: SHOW, oPAT_SEL=0, oBLANKING=0.
6. With VGA_PAT_SEQ_OSD_EN and oPAT_SEL=2: pixel (23,7) -> RGB (1023,0,0); pixels (24,7) and (23,8) -> pattern 2 values.
